ftdi_fifo_host_emu: RTL and testbench

Synthesizable emulator of the FT232H 245-FIFO host side, parametrised in packet count, packet length and handshake timing. It replaces the behavioural rxf/txe/ADBUS driver loops with an on-chip block for board self-test and loopback.
- Source engine feeds framed packets into the FPGA read path.
- Sink engine accepts bytes from the FPGA write path, counts them and optionally checks them.
- Sits outside the design under test on the GPIO FIFO pins, or in a board-level loopback wrapper.

---
 rtl/ftdi_fifo_host_emu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ftdi_fifo_host_emu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_host_emu.sv
// FT232H 245-FIFO host-side emulator: a source engine offers framed packets to the
// FPGA read path and a sink engine counts FPGA writes. Optional byte checker: FTDI_EMU_CHECK_EN.
module ftdi_fifo_host_emu #(
   parameter int unsigned NUM_PKTS     = 2,
   parameter int unsigned PKT_LEN      = 8,
   parameter int unsigned STOP_LEN     = 2,
   parameter logic [7:0]  START_SEQ    = 8'hA5,
   parameter logic [7:0]  STOP_SEQ     = 8'h5A,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter int unsigned TXE_HOLD     = 1,
   parameter int unsigned EXPECT_BYTES = 16
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        start,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic [7:0]  adbus_in,
   output logic        rxf_n,
   output logic        txe_n,
   output logic [7:0]  adbus_out,
   output logic        adbus_oe,
   output logic [15:0] rx_count,
   output logic [7:0]  err_count,
   output logic        proto_err,
   output logic        done,
   output logic        pass
);

   localparam logic [7:0]  LP_LAST_PKT      = 8'(NUM_PKTS - 1);
   localparam logic [7:0]  LP_PKT_LAST_IDX  = 8'(PKT_LEN - 1);
   localparam logic [7:0]  LP_STOP_LAST_IDX = 8'(STOP_LEN - 1);
   localparam logic [3:0]  LP_GAP_LOAD      = 4'(GAP_CYCLES - 1);
   localparam logic [3:0]  LP_HOLD_LOAD     = 4'(TXE_HOLD - 1);
   localparam logic [15:0] LP_EXPECT        = 16'(EXPECT_BYTES);

   typedef enum logic [2:0] {
      SRC_IDLE  = 3'd0,
      SRC_OFFER = 3'd1,
      SRC_DRIVE = 3'd2,
      SRC_GAP   = 3'd3,
      SRC_DONE  = 3'd4
   } src_state_t;

   typedef enum logic [1:0] {
      SNK_IDLE  = 2'd0,
      SNK_READY = 2'd1,
      SNK_HOLD  = 2'd2,
      SNK_DONE  = 2'd3
   } snk_state_t;

   // Byte at position idx of packet pkt: header byte, then the payload index itself.
   function automatic logic [7:0] f_stream_byte(input logic [7:0] pkt, input logic [7:0] idx);
      logic [7:0] v;
      if (idx != 8'd0) begin
         v = idx;
      end else if (pkt == LP_LAST_PKT) begin
         v = STOP_SEQ;
      end else begin
         v = START_SEQ;
      end
      return v;
   endfunction

   function automatic logic [7:0] f_last_idx(input logic [7:0] pkt);
      return (pkt == LP_LAST_PKT) ? LP_STOP_LAST_IDX : LP_PKT_LAST_IDX;
   endfunction

   src_state_t  r_src_state;
   snk_state_t  r_snk_state;
   logic [7:0]  r_src_pkt;
   logic [7:0]  r_src_idx;
   logic        r_src_last;
   logic [3:0]  r_gap_cnt;
   logic        r_rxf_n;
   logic        r_oe;
   logic [7:0]  r_dout;
   logic        r_txe_n;
   logic [3:0]  r_hold_cnt;
   logic [15:0] r_rx_count;
   logic        r_wr_prev;
   logic        r_proto_err;
   logic        r_done;
   logic [7:0]  w_err_count;
   logic        w_launch;
   logic        w_both_done;
   logic        w_capture;

   assign w_launch    = start && (r_src_state == SRC_IDLE) && (r_snk_state == SNK_IDLE);
   assign w_both_done = (r_src_state == SRC_DONE) && (r_snk_state == SNK_DONE);
   // A capture needs a fresh falling strobe: wr_n held low across cycles is one write.
   assign w_capture   = (r_snk_state == SNK_READY) && !wr_n && r_wr_prev;

   // Source engine: offers bytes on rxf_n and drives ADBUS while the FPGA reads.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_src_state <= SRC_IDLE;
         r_src_pkt   <= 8'd0;
         r_src_idx   <= 8'd0;
         r_src_last  <= 1'b0;
         r_gap_cnt   <= 4'd0;
         r_rxf_n     <= 1'b1;
         r_oe        <= 1'b0;
         r_dout      <= 8'd0;
      end else begin
         case (r_src_state)
            SRC_IDLE: begin
               if (w_launch) begin
                  r_src_pkt   <= 8'd0;
                  r_src_idx   <= 8'd0;
                  r_src_last  <= 1'b0;
                  r_rxf_n     <= 1'b0;
                  r_src_state <= SRC_OFFER;
               end
            end
            SRC_OFFER: begin
               if (!rd_n) begin
                  r_oe        <= 1'b1;
                  r_dout      <= f_stream_byte(r_src_pkt, r_src_idx);
                  r_src_state <= SRC_DRIVE;
               end
            end
            SRC_DRIVE: begin
               if (rd_n) begin
                  r_oe        <= 1'b0;
                  r_rxf_n     <= 1'b1;
                  r_gap_cnt   <= LP_GAP_LOAD;
                  r_src_state <= SRC_GAP;
                  if (r_src_idx == f_last_idx(r_src_pkt)) begin
                     r_src_idx <= 8'd0;
                     if (r_src_pkt == LP_LAST_PKT) begin
                        r_src_last <= 1'b1;
                     end else begin
                        r_src_pkt <= r_src_pkt + 8'd1;
                     end
                  end else begin
                     r_src_idx <= r_src_idx + 8'd1;
                  end
               end
            end
            SRC_GAP: begin
               if (r_gap_cnt == 4'd0) begin
                  if (r_src_last) begin
                     r_src_state <= SRC_DONE;
                  end else begin
                     r_rxf_n     <= 1'b0;
                     r_src_state <= SRC_OFFER;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
               end
            end
            SRC_DONE: begin
               if (w_both_done) begin
                  r_src_state <= SRC_IDLE;
               end
            end
            default: begin
               r_src_state <= SRC_IDLE;
               r_rxf_n     <= 1'b1;
               r_oe        <= 1'b0;
            end
         endcase
      end
   end

   // Sink engine: accepts writes while txe_n is low and flags writes outside that window.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_snk_state <= SNK_IDLE;
         r_txe_n     <= 1'b1;
         r_hold_cnt  <= 4'd0;
         r_rx_count  <= 16'd0;
         r_wr_prev   <= 1'b1;
         r_proto_err <= 1'b0;
      end else begin
         r_wr_prev <= wr_n;
         if (w_launch) begin
            r_proto_err <= 1'b0;
         end else if (!wr_n && r_txe_n && (r_snk_state != SNK_IDLE)) begin
            r_proto_err <= 1'b1;
         end
         case (r_snk_state)
            SNK_IDLE: begin
               if (w_launch) begin
                  r_rx_count  <= 16'd0;
                  r_txe_n     <= 1'b0;
                  r_snk_state <= SNK_READY;
               end
            end
            SNK_READY: begin
               if (w_capture) begin
                  r_rx_count  <= (r_rx_count == 16'hFFFF) ? r_rx_count : r_rx_count + 16'd1;
                  r_txe_n     <= 1'b1;
                  r_hold_cnt  <= LP_HOLD_LOAD;
                  r_snk_state <= SNK_HOLD;
               end
            end
            SNK_HOLD: begin
               if (r_hold_cnt == 4'd0) begin
                  if (r_rx_count >= LP_EXPECT) begin
                     r_snk_state <= SNK_DONE;
                  end else begin
                     r_txe_n     <= 1'b0;
                     r_snk_state <= SNK_READY;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt - 4'd1;
               end
            end
            SNK_DONE: begin
               if (w_both_done) begin
                  r_snk_state <= SNK_IDLE;
               end
            end
            default: begin
               r_snk_state <= SNK_IDLE;
               r_txe_n     <= 1'b1;
            end
         endcase
      end
   end

   // Run-complete flag, held until the next honoured start.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_done <= 1'b0;
      end else if (w_launch) begin
         r_done <= 1'b0;
      end else if (w_both_done) begin
         r_done <= 1'b1;
      end
   end

`ifdef FTDI_EMU_CHECK_EN
   logic [7:0] r_exp_pkt;
   logic [7:0] r_exp_idx;
   logic [7:0] r_err_count;

   // Expected-stream generator and comparator; wraps to packet 0 after the stop packet.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_exp_pkt   <= 8'd0;
         r_exp_idx   <= 8'd0;
         r_err_count <= 8'd0;
      end else if (w_launch) begin
         r_exp_pkt   <= 8'd0;
         r_exp_idx   <= 8'd0;
         r_err_count <= 8'd0;
      end else if (w_capture) begin
         if ((adbus_in != f_stream_byte(r_exp_pkt, r_exp_idx)) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
         if (r_exp_idx == f_last_idx(r_exp_pkt)) begin
            r_exp_idx <= 8'd0;
            r_exp_pkt <= (r_exp_pkt == LP_LAST_PKT) ? 8'd0 : r_exp_pkt + 8'd1;
         end else begin
            r_exp_idx <= r_exp_idx + 8'd1;
         end
      end
   end

   assign w_err_count = r_err_count;
`else
   assign w_err_count = 8'd0;
`endif

   assign rxf_n     = r_rxf_n;
   assign txe_n     = r_txe_n;
   assign adbus_out = r_dout;
   assign adbus_oe  = r_oe;
   assign rx_count  = r_rx_count;
   assign err_count = w_err_count;
   assign proto_err = r_proto_err;
   assign done      = r_done;
   assign pass      = r_done && (w_err_count == 8'd0) && !r_proto_err;

endmodule

// File: tb/tb_ftdi_fifo_host_emu.sv
// Directed bench for ftdi_fifo_host_emu with default parameters: stream order,
// handshake timing, protocol error, mid-run reset and ignored start pulses.
module tb_ftdi_fifo_host_emu;

   logic        clock = 1'b0;
   logic        resetN;
   logic        start;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  adbus_in;
   logic        rxf_n;
   logic        txe_n;
   logic [7:0]  adbus_out;
   logic        adbus_oe;
   logic [15:0] rx_count;
   logic [7:0]  err_count;
   logic        proto_err;
   logic        done;
   logic        pass;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] got_arr [10];
   logic [7:0] got;

   ftdi_fifo_host_emu dut (
      .clock(clock), .resetN(resetN), .start(start), .rd_n(rd_n), .wr_n(wr_n),
      .adbus_in(adbus_in), .rxf_n(rxf_n), .txe_n(txe_n), .adbus_out(adbus_out),
      .adbus_oe(adbus_oe), .rx_count(rx_count), .err_count(err_count),
      .proto_err(proto_err), .done(done), .pass(pass)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Source stream for default parameters: A5,01..07,5A,01 repeating.
   function automatic logic [7:0] stream(input int n);
      int m;
      m = n % 10;
      if (m == 0) return 8'hA5;
      if (m == 8) return 8'h5A;
      if (m == 9) return 8'h01;
      return 8'(m);
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic read_byte(input logic [7:0] exp, input bit last, output logic [7:0] b);
      int w;
      w = 0;
      while (rxf_n !== 1'b0 && w < 50) begin
         tick();
         w++;
      end
      check("rxf_offer", rxf_n, 1'b0);
      rd_n = 1'b0;
      tick();
      check("oe_drive", adbus_oe, 1'b1);
      check("rd_byte", adbus_out, exp);
      b = adbus_out;
      rd_n = 1'b1;
      tick();
      check("oe_release", adbus_oe, 1'b0);
      check("rxf_gap0", rxf_n, 1'b1);
      tick();
      check("rxf_gap1", rxf_n, 1'b1);
      tick();
      check("rxf_after_gap", rxf_n, last ? 1'b1 : 1'b0);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic [15:0] exp_cnt, input bit hold_low);
      int w;
      w = 0;
      while (txe_n !== 1'b0 && w < 50) begin
         tick();
         w++;
      end
      check("txe_ready", txe_n, 1'b0);
      adbus_in = b;
      wr_n = 1'b0;
      tick();
      check("txe_after_wr", txe_n, 1'b1);
      check("rx_count", rx_count, exp_cnt);
      if (hold_low) begin
         check("proto_before_hold", proto_err, 1'b0);
         tick();
         check("proto_set", proto_err, 1'b1);
         check("rx_count_hold", rx_count, exp_cnt);
         check("txe_back_ready", txe_n, 1'b0);
         tick();
         check("no_recapture", rx_count, exp_cnt);
      end
      wr_n = 1'b1;
      tick();
   endtask

   initial begin
      resetN = 1'b0; start = 1'b0; rd_n = 1'b1; wr_n = 1'b1; adbus_in = 8'h00;
      tick(); tick();
      check("rst_rxf", rxf_n, 1'b1);
      check("rst_txe", txe_n, 1'b1);
      check("rst_oe", adbus_oe, 1'b0);
      check("rst_dout", adbus_out, 8'h00);
      check("rst_rxcnt", rx_count, 16'h0000);
      check("rst_err", err_count, 8'h00);
      check("rst_proto", proto_err, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      resetN = 1'b1;
      tick();

      // Strobes while idle are ignored.
      rd_n = 1'b0; wr_n = 1'b0;
      tick(); tick();
      check("idle_rd_oe", adbus_oe, 1'b0);
      check("idle_wr_proto", proto_err, 1'b0);
      rd_n = 1'b1; wr_n = 1'b1;
      tick();

      // Run 1: read the full stream, write 00..0F, with a stray start mid-run.
      pulse_start();
      check("r1_rxf", rxf_n, 1'b0);
      check("r1_txe", txe_n, 1'b0);
      for (int n = 0; n < 10; n++) begin
         if (n == 3) begin
            pulse_start();
            check("midrun_start_rxf", rxf_n, 1'b0);
            check("midrun_start_cnt", rx_count, 16'h0000);
         end
         read_byte(stream(n), (n == 9), got);
      end
      for (int n = 0; n < 16; n++) begin
         write_byte(8'(n), 16'(n + 1), 1'b0);
      end
      check("r1_snk_done_txe", txe_n, 1'b1);
      check("r1_done_early", done, 1'b0);
      tick();
      check("r1_done", done, 1'b1);
      check("r1_proto", proto_err, 1'b0);
`ifdef FTDI_EMU_CHECK_EN
      check("r1_err", err_count, 8'd9);
      check("r1_pass", pass, 1'b0);
`else
      check("r1_err", err_count, 8'd0);
      check("r1_pass", pass, 1'b1);
`endif
      tick(); tick();
      check("r1_done_held", done, 1'b1);
      check("r1_idle_rxf", rxf_n, 1'b1);
      check("r1_idle_txe", txe_n, 1'b1);

      // Run 2: loopback, first read with rd_n held low for 5 cycles.
      pulse_start();
      check("r2_done_clr", done, 1'b0);
      check("r2_cnt_clr", rx_count, 16'h0000);
      rd_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("held_oe", adbus_oe, 1'b1);
      end
      check("held_byte", adbus_out, 8'hA5);
      got_arr[0] = adbus_out;
      rd_n = 1'b1;
      tick();
      check("held_oe_off", adbus_oe, 1'b0);
      check("held_gap0", rxf_n, 1'b1);
      tick();
      check("held_gap1", rxf_n, 1'b1);
      tick();
      check("held_reoffer", rxf_n, 1'b0);
      for (int n = 1; n < 10; n++) begin
         read_byte(stream(n), (n == 9), got);
         got_arr[n] = got;
      end
      for (int n = 0; n < 16; n++) begin
         write_byte((n < 10) ? got_arr[n] : stream(n), 16'(n + 1), 1'b0);
      end
      check("r2_done_early", done, 1'b0);
      tick();
      check("r2_done", done, 1'b1);
      check("r2_err", err_count, 8'd0);
      check("r2_proto", proto_err, 1'b0);
      check("r2_pass", pass, 1'b1);

      // Run 3: first write held low into HOLD raises proto_err.
      pulse_start();
      write_byte(stream(0), 16'd1, 1'b1);
      for (int n = 1; n < 16; n++) begin
         write_byte(stream(n), 16'(n + 1), 1'b0);
      end
      for (int n = 0; n < 10; n++) begin
         read_byte(stream(n), (n == 9), got);
      end
      check("r3_done_early", done, 1'b0);
      tick();
      check("r3_done", done, 1'b1);
      check("r3_rxcnt", rx_count, 16'd16);
      check("r3_proto", proto_err, 1'b1);
      check("r3_pass", pass, 1'b0);

      // Run 4: reset while the source drives ADBUS, then rerun from packet 0.
      pulse_start();
      check("r4_proto_clr", proto_err, 1'b0);
      rd_n = 1'b0;
      tick();
      check("r4_drive_oe", adbus_oe, 1'b1);
      #2;
      resetN = 1'b0;
      #1;
      check("r4_async_oe", adbus_oe, 1'b0);
      check("r4_async_rxf", rxf_n, 1'b1);
      check("r4_async_txe", txe_n, 1'b1);
      check("r4_async_dout", adbus_out, 8'h00);
      check("r4_async_done", done, 1'b0);
      rd_n = 1'b1;
      tick();
      resetN = 1'b1;
      tick();
      check("r4_idle_rxf", rxf_n, 1'b1);
      pulse_start();
      read_byte(8'hA5, 1'b0, got);
      read_byte(8'h01, 1'b0, got);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
